// File: rtl/rf_ctrl.sv
// rf_ctrl: four-state register-file ALU sequencer (IDLE/READ/EXEC/WB).
// Defining RF_CTRL_FLAGS_EN adds zero/carry flag outputs that update on writeback.
module rf_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_sr1,
  input  logic [ADDR_W-1:0] cmd_sr2,
  input  logic [ADDR_W-1:0] cmd_dr,
  output logic [ADDR_W-1:0] rf_sr1,
  output logic [ADDR_W-1:0] rf_sr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_write,
  output logic              busy,
  output logic              done
`ifdef RF_CTRL_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3;
  logic [1:0]        state, state_nx;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] sr1_q, sr2_q, dr_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
`ifdef RF_CTRL_FLAGS_EN
  logic              c_q;
  logic [DATA_W:0]   alu;
  always_comb alu = op_q == 2'b00 ? {1'b0, a_q} + {1'b0, b_q} :
                    op_q == 2'b01 ? {1'b0, a_q} - {1'b0, b_q} :
                    {1'b0, op_q[0] ? (a_q | b_q) : (a_q & b_q)};
`else
  logic [DATA_W-1:0] alu;
  always_comb alu = op_q == 2'b00 ? a_q + b_q :
                    op_q == 2'b01 ? a_q - b_q :
                    op_q[0] ? (a_q | b_q) : (a_q & b_q);
`endif
  // States are sequential in encoding, so every non-idle state just advances (WB wraps to IDLE)
  always_comb state_nx = (state == IDLE && !cmd_valid) ? IDLE : state + 2'd1;
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign rf_write   = state == WB;
  assign done       = state == WB;
  assign rf_sr1     = sr1_q;
  assign rf_sr2     = sr2_q;
  assign rf_dr      = dr_q;
  assign rf_wr_data = res_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      sr1_q <= '0;
      sr2_q <= '0;
      dr_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
`ifdef RF_CTRL_FLAGS_EN
      c_q    <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (cmd_valid && cmd_ready) begin
        op_q  <= cmd_op;
        sr1_q <= cmd_sr1;
        sr2_q <= cmd_sr2;
        dr_q  <= cmd_dr;
      end
      if (state == READ) begin
        a_q <= rf_rd_data1;
        b_q <= rf_rd_data2;
      end
`ifdef RF_CTRL_FLAGS_EN
      if (state == EXEC) {c_q, res_q} <= alu;
      if (state == WB) begin
        flag_z <= res_q == '0;
        flag_c <= c_q;
      end
`else
      if (state == EXEC) res_q <= alu;
`endif
    end
  end
endmodule

// File: tb/tb_rf_ctrl.sv
// tb_rf_ctrl: randomized and directed checks of rf_ctrl against a command-level model.
module tb_rf_ctrl;
  localparam int DW = 32, AW = 2;
  logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_sr1 = '0, cmd_sr2 = '0, cmd_dr = '0;
  logic          cmd_ready, rf_write, busy, done;
  logic [AW-1:0] rf_sr1, rf_sr2, rf_dr;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
`ifdef RF_CTRL_FLAGS_EN
  logic          flag_z, flag_c;
`endif
  rf_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2), .cmd_dr(cmd_dr),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_dr(rf_dr), .rf_wr_data(rf_wr_data), .rf_write(rf_write), .busy(busy), .done(done)
`ifdef RF_CTRL_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // register file environment with a preload port for test setup
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_i = '0;
  logic [DW-1:0] pre_v = '0;
  logic [DW-1:0] rf [4];
  assign rf_rd_data1 = rf[rf_sr1];
  assign rf_rd_data2 = rf[rf_sr2];
  always @(posedge clk)
    if (rf_write) rf[rf_dr] <= rf_wr_data;
    else if (pre_en) rf[pre_i] <= pre_v;

  // command-level model: a command accepted while idle writes op(R[sr1],R[sr2]) three edges later
  logic [DW-1:0] mrf [4];
  int            rem = 0, cyc = 0;
  logic [AW-1:0] edr = '0, msr1 = '0, msr2 = '0;
  logic [DW-1:0] eval = '0, ma, mb;
  logic [DW:0]   w;
  logic          ez = 1'b0, ec = 1'b0, mz = 1'b0, mc = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (pre_en) mrf[pre_i] = pre_v;
    if (!rst_n) begin
      rem = 0; msr1 = '0; msr2 = '0; mz = 1'b0; mc = 1'b0;
    end else begin
      cyc++;
      if (rem == 1) begin
        mrf[edr] = eval; mz = ez; mc = ec; rem = 0;
      end else if (rem > 1) rem--;
      else if (cmd_valid) begin
        ma = mrf[cmd_sr1]; mb = mrf[cmd_sr2];
        case (cmd_op)
          2'b00: begin w = {1'b0, ma} + {1'b0, mb}; ec = w[DW]; end
          2'b01: begin w = {1'b0, ma - mb}; ec = ma < mb; end
          2'b10: begin w = {1'b0, ma & mb}; ec = 1'b0; end
          default: begin w = {1'b0, ma | mb}; ec = 1'b0; end
        endcase
        eval = w[DW-1:0]; ez = eval == '0;
        edr = cmd_dr; msr1 = cmd_sr1; msr2 = cmd_sr2; rem = 3;
      end
    end
  end

  int dut_hs = 0;
  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) dut_hs++;

  int            wr_seen = 0, wr_cyc = 0;
  logic [AW-1:0] last_dr = '0;
  logic [DW-1:0] last_data = '0;
  always @(negedge clk) begin
    chk("busy", busy, rem != 0);
    chk("cmd_ready", cmd_ready, rem == 0);
    chk("rf_write", rf_write, rem == 1);
    chk("done", done, rem == 1);
    chk("rf_sr1", rf_sr1, msr1);
    chk("rf_sr2", rf_sr2, msr2);
    if (rem == 1) begin
      chk("rf_dr", rf_dr, edr);
      chk("rf_wr_data", rf_wr_data, eval);
    end
`ifdef RF_CTRL_FLAGS_EN
    chk("flag_z", flag_z, mz);
    chk("flag_c", flag_c, mc);
`endif
    if (rf_write) begin
      wr_seen++; wr_cyc = cyc; last_dr = rf_dr; last_data = rf_wr_data;
    end
  end

  task automatic setreg(input logic [AW-1:0] i, input logic [DW-1:0] v);
    pre_en = 1'b1; pre_i = i; pre_v = v;
    @(negedge clk); #1;
    pre_en = 1'b0;
  endtask

  // call just after a negedge with the controller idle
  task automatic run(input logic [1:0] op, input logic [AW-1:0] dr, s1, s2,
                     input logic [DW-1:0] exp, input logic ez_x, ec_x, input string n);
    int w0, c0;
    bit got;
    w0 = wr_seen; got = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dr = dr; cmd_sr1 = s1; cmd_sr2 = s2;
    @(negedge clk); #1;
    c0 = cyc;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_dr = AW'($urandom);
    cmd_sr1 = AW'($urandom); cmd_sr2 = AW'($urandom);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      got = wr_seen != w0;
    end
    chk({n, "_written"}, got, 1'b1);
    chk({n, "_data"}, last_data, exp);
    chk({n, "_dr"}, last_dr, dr);
    chk({n, "_latency"}, wr_cyc + 1 - c0, 3);
    @(negedge clk); #1;
`ifdef RF_CTRL_FLAGS_EN
    chk({n, "_flag_z"}, flag_z, ez_x);
    chk({n, "_flag_c"}, flag_c, ec_x);
`endif
  endtask

  initial begin
    int w0, h0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_write", rf_write, 1'b0);
    chk("rst_dr", rf_dr, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_sr1", rf_sr1, 0);
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) setreg(AW'(i), $urandom);
    setreg(1, 5); setreg(2, 3);
    rst_n = 1'b1;
    run(2'b00, 0, 1, 2, 32'd8, 1'b0, 1'b0, "add");
    setreg(1, 2); setreg(2, 3);
    run(2'b01, 3, 1, 2, 32'hFFFF_FFFF, 1'b0, 1'b1, "sub");
    setreg(0, 32'hFFFF_FFFF); setreg(1, 1);
    run(2'b00, 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b1, "add_self");
    run(2'b00, 2, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, "add_wbr");
    setreg(1, 32'hF0F0_F0F0); setreg(2, 32'h0F0F_0F0F);
    run(2'b10, 3, 1, 2, 32'd0, 1'b1, 1'b0, "and");
    h0 = dut_hs;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_dr = 1; cmd_sr1 = 2; cmd_sr2 = 3;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    chk("hold_valid_handshakes", dut_hs - h0, 2);
    repeat (4) @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dr = 1; cmd_sr1 = 2; cmd_sr2 = 3;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    w0 = wr_seen;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_write", rf_write, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("abort_no_write", wr_seen - w0, 0);
    setreg(2, 10); setreg(3, 4);
    run(2'b01, 1, 2, 3, 32'd6, 1'b0, 1'b0, "after_abort");
    repeat (600) begin
      cmd_valid = ($urandom % 3) != 0;
      cmd_op = 2'($urandom); cmd_dr = AW'($urandom);
      cmd_sr1 = AW'($urandom); cmd_sr2 = AW'($urandom);
      @(negedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("final_reg", rf[i], mrf[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_ctrl.md
RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, register data width; ADDR_W, 2, register index width (4 registers).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_sr1  input  ADDR_W  operand A register index
- cmd_sr2  input  ADDR_W  operand B register index
- cmd_dr  input  ADDR_W  destination register index
- rf_sr1  output  ADDR_W  register-file read select 1
- rf_sr2  output  ADDR_W  register-file read select 2
- rf_rd_data1  input  DATA_W  register-file read data 1, combinational from rf_sr1
- rf_rd_data2  input  DATA_W  register-file read data 2, combinational from rf_sr2
- rf_dr  output  ADDR_W  register-file write index
- rf_wr_data  output  DATA_W  register-file write data
- rf_write  output  1  register-file write enable, sampled by the file on rising clk
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, coincident with rf_write
REQ-003 One clock; reset is asynchronous and active-low; clock port is clk and reset port is rst_n.

Function
REQ-004 FSM SHALL have four states: IDLE, READ, EXEC, WB, with transitions IDLE->READ on handshake, READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-005 cmd_ready SHALL equal (state==IDLE), decoded combinationally; a handshake SHALL occur on a rising edge with cmd_valid && cmd_ready.
REQ-006 On handshake, cmd_op, cmd_sr1, cmd_sr2 and cmd_dr SHALL be latched; later changes on cmd_* SHALL have no effect.
REQ-007 rf_sr1/rf_sr2 SHALL drive the latched indices in READ; rf_rd_data1/2 SHALL be captured into operand registers A/B at the READ->EXEC edge.
REQ-008 EXEC SHALL register result = A+B, A-B, A&B or A|B per op; arithmetic is modulo 2^DATA_W.
REQ-009 In WB, rf_write=1, rf_dr=latched dr, rf_wr_data=result and done=1 SHALL hold for exactly one cycle; outside WB, rf_write=0 and done=0.
REQ-010 Latency: handshake on edge N SHALL produce the register-file write on edge N+3; sustained throughput SHALL be one command per 4 cycles.
REQ-011 dr equal to sr1 and/or sr2 SHALL be legal; operands are the pre-write values.
REQ-012 The next command's READ SHALL observe the value written by the previous WB; there is no hazard, because IDLE separates WB from READ.
REQ-013 rf_sr1/rf_sr2 SHALL hold the last latched indices outside READ; initial value after reset is 0.

Reset
REQ-014 rst_n low SHALL immediately force state=IDLE, rf_write=0, done=0, busy=0 and cmd_ready=1 (once rst_n releases), without waiting for clk.
REQ-015 Reset SHALL clear operand, result, latched-command and flag registers to 0; rf_sr1, rf_sr2, rf_dr and rf_wr_data SHALL read 0.
REQ-016 Reset asserted during READ, EXEC or WB SHALL abort the command with no register-file write issued.
REQ-017 The first handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-018 With macro RF_CTRL_FLAGS_EN defined, outputs flag_z (1 bit) and flag_c (1 bit) SHALL exist and update at the WB->IDLE edge.
- flag_z = (result==0).
- flag_c = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 for AND/OR.
- Both flags hold until the next WB and reset to 0.
REQ-019 Without RF_CTRL_FLAGS_EN, flag_z and flag_c SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-020 R1=5, R2=3; ADD dr=0 sr1=1 sr2=2 -> rf_write with rf_dr=0, rf_wr_data=8 exactly 3 edges after handshake; done coincident.
REQ-021 R1=2, R2=3; SUB dr=3 -> rf_wr_data=0xFFFFFFFF; with RF_CTRL_FLAGS_EN, flag_c=1 and flag_z=0.
REQ-022 R0=0xFFFFFFFF, R1=1; ADD dr=0 sr1=0 sr2=0 -> 0xFFFFFFFE; then ADD dr=2 sr1=0 sr2=1 -> 0xFFFFFFFF, proving write-before-read.
REQ-023 cmd_valid held high for 8 cycles -> exactly 2 handshakes, cmd_ready low in READ/EXEC/WB.
REQ-024 rst_n pulled low in EXEC -> rf_write never asserts, busy=0 immediately, and the next command completes normally.
REQ-025 AND 0xF0F0F0F0 & 0x0F0F0F0F -> 0; with RF_CTRL_FLAGS_EN, flag_z=1 and flag_c=0.
